// File: rtl/qreg_write_arbiter.sv
// Round-robin write arbiter: one requester granted at a time, optional burst hold, one-hot reg write issue.
// Latency: transfer at edge t -> reg_w_en/reg_wdata valid in cycle t+1. Throughput 1 transfer/cycle.
// Backpressure: req_ready is combinational; non-owners stall during BURST. Define QREG_ARB_ERR_EN for the sticky err flag.
module qreg_write_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int NUM_REGS  = 8,
    parameter int DATA_W    = 32,
    parameter int MAX_BURST = 4,
    localparam int ADDR_W   = $clog2(NUM_REGS),
    localparam int ID_W     = $clog2(NUM_REQ)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_REQ-1:0]          req_valid,
    output logic [NUM_REQ-1:0]          req_ready,
    input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
    input  logic [NUM_REQ*DATA_W-1:0]   req_data,
    input  logic [NUM_REQ-1:0]          req_last,
    output logic [NUM_REGS-1:0]         reg_w_en,
    output logic [DATA_W-1:0]           reg_wdata,
    output logic [ID_W-1:0]             grant_id,
    output logic                        busy,
    output logic                        err
);

    localparam int CNT_W = $clog2(MAX_BURST + 1);

    typedef enum logic {IDLE = 1'b0, BURST = 1'b1} state_e;

    state_e                 state_q, state_d;
    logic [ID_W-1:0]        rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]        grant_id_q, grant_id_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [NUM_REGS-1:0]    reg_w_en_q, reg_w_en_d;
    logic [DATA_W-1:0]      reg_wdata_q, reg_wdata_d;

    logic [ID_W-1:0]        winner;
    logic                   winner_vld;
    logic [ID_W-1:0]        sel;
    logic                   sel_vld;
    logic                   xfer;
    logic [ADDR_W-1:0]      sel_addr;
    logic [DATA_W-1:0]      sel_data;
    logic                   sel_last;
    logic                   addr_ok;
    logic [ID_W-1:0]        sel_next;

    // Descending scan so the requester closest to rr_ptr is assigned last and wins.
    always_comb begin
        int idx;
        winner     = rr_ptr_q;
        winner_vld = 1'b0;
        idx        = 0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = (int'(rr_ptr_q) + k) % NUM_REQ;
            if (req_valid[idx]) begin
                winner     = ID_W'(idx);
                winner_vld = 1'b1;
            end
        end
    end

    always_comb begin
        sel      = (state_q == IDLE) ? winner : grant_id_q;
        sel_vld  = (state_q == IDLE) ? winner_vld : req_valid[grant_id_q];
        xfer     = sel_vld & ~rst;
        sel_addr = req_addr[int'(sel)*ADDR_W +: ADDR_W];
        sel_data = req_data[int'(sel)*DATA_W +: DATA_W];
        sel_last = req_last[sel];
        addr_ok  = ({1'b0, sel_addr} < (ADDR_W + 1)'(NUM_REGS));
        sel_next = (sel == ID_W'(NUM_REQ - 1)) ? '0 : sel + ID_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            grant_id_q  <= '0;
            cnt_q       <= '0;
            reg_w_en_q  <= '0;
            reg_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            grant_id_q  <= grant_id_d;
            cnt_q       <= cnt_d;
            reg_w_en_q  <= reg_w_en_d;
            reg_wdata_q <= reg_wdata_d;
        end
    end

    // cnt_q is 0 in IDLE, so the same release test covers MAX_BURST=1 single grants.
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        grant_id_d  = grant_id_q;
        cnt_d       = cnt_q;
        reg_w_en_d  = '0;
        reg_wdata_d = reg_wdata_q;
        if (xfer) begin
            grant_id_d  = sel;
            reg_wdata_d = sel_data;
            if (addr_ok) begin
                reg_w_en_d[sel_addr] = 1'b1;
            end
            if (sel_last || (cnt_q == CNT_W'(MAX_BURST - 1))) begin
                state_d  = IDLE;
                cnt_d    = '0;
                rr_ptr_d = sel_next;
            end else begin
                state_d  = BURST;
                cnt_d    = cnt_q + CNT_W'(1);
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (xfer) begin
            req_ready[sel] = 1'b1;
        end
    end

    assign reg_w_en  = reg_w_en_q;
    assign reg_wdata = reg_wdata_q;
    assign grant_id  = grant_id_q;
    assign busy      = (state_q == BURST);

`ifdef QREG_ARB_ERR_EN
    logic err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (xfer && !addr_ok) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_qreg_write_arbiter.sv
// Bench for qreg_write_arbiter with 6 registers so out-of-range addresses exist.
module tb_qreg_write_arbiter;

    localparam int NUM_REQ   = 4;
    localparam int NUM_REGS  = 6;
    localparam int DATA_W    = 32;
    localparam int MAX_BURST = 4;
    localparam int ADDR_W    = $clog2(NUM_REGS);
    localparam int ID_W      = $clog2(NUM_REQ);
`ifdef QREG_ARB_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic                       clk;
    logic                       rst;
    logic [NUM_REQ-1:0]         req_valid;
    logic [NUM_REQ-1:0]         req_ready;
    logic [NUM_REQ*ADDR_W-1:0]  req_addr;
    logic [NUM_REQ*DATA_W-1:0]  req_data;
    logic [NUM_REQ-1:0]         req_last;
    logic [NUM_REGS-1:0]        reg_w_en;
    logic [DATA_W-1:0]          reg_wdata;
    logic [ID_W-1:0]            grant_id;
    logic                       busy;
    logic                       err;

    qreg_write_arbiter #(
        .NUM_REQ   (NUM_REQ),
        .NUM_REGS  (NUM_REGS),
        .DATA_W    (DATA_W),
        .MAX_BURST (MAX_BURST)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .req_last  (req_last),
        .reg_w_en  (reg_w_en),
        .reg_wdata (reg_wdata),
        .grant_id  (grant_id),
        .busy      (busy),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    bit checking = 1'b0;

    logic [NUM_REGS-1:0] sb_q[$];
    int gnt_log[$];
    int exp_log[$];

    task automatic check_val(string tag, logic [63:0] got, logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_log(string tag);
        int n;
        check_val({tag, "_len"}, 64'(gnt_log.size()), 64'(exp_log.size()));
        n = (gnt_log.size() < exp_log.size()) ? gnt_log.size() : exp_log.size();
        for (int i = 0; i < n; i++) begin
            check_val(tag, 64'(gnt_log[i]), 64'(exp_log[i]));
        end
        gnt_log.delete();
    endtask

    // Reference model state, as it stands after the most recent rising edge.
    bit                  m_busy  = 1'b0;
    int                  m_ptr   = 0;
    int                  m_owner = 0;
    int                  m_cnt   = 0;
    bit                  m_err   = 1'b0;
    logic [DATA_W-1:0]   m_wdata = '0;
    int                  m_sel;
    logic [NUM_REQ-1:0]  m_rdy;
    logic [NUM_REGS-1:0] m_wen;
    int                  m_addr;

    always @(negedge clk) begin
        if (checking) begin
            m_wen = '0;
            if (sb_q.size() > 0) m_wen = sb_q.pop_front();
            check_val("reg_w_en", 64'(reg_w_en), 64'(m_wen));
            check_val("reg_wdata", 64'(reg_wdata), 64'(m_wdata));
            check_val("busy", 64'(busy), 64'(m_busy));
            check_val("grant_id", 64'(grant_id), 64'(m_owner));
            check_val("err", 64'(err), 64'(m_err));

            m_sel = -1;
            m_rdy = '0;
            if (!rst) begin
                if (m_busy) begin
                    if (req_valid[m_owner]) m_sel = m_owner;
                end else begin
                    for (int k = 0; k < NUM_REQ; k++) begin
                        if (m_sel < 0 && req_valid[(m_ptr + k) % NUM_REQ]) m_sel = (m_ptr + k) % NUM_REQ;
                    end
                end
                if (m_sel >= 0) m_rdy[m_sel] = 1'b1;
            end
            check_val("req_ready", 64'(req_ready), 64'(m_rdy));

            for (int i = 0; i < NUM_REQ; i++) begin
                if (!rst && req_valid[i] && req_ready[i]) gnt_log.push_back(i);
            end

            if (rst) begin
                m_busy = 1'b0; m_ptr = 0; m_owner = 0; m_cnt = 0; m_err = 1'b0; m_wdata = '0;
                sb_q.delete();
            end else if (m_sel >= 0) begin
                m_addr  = int'(req_addr[m_sel*ADDR_W +: ADDR_W]);
                m_wdata = req_data[m_sel*DATA_W +: DATA_W];
                m_wen   = '0;
                if (m_addr < NUM_REGS) m_wen[m_addr] = 1'b1;
                else if (ERR_EN) m_err = 1'b1;
                sb_q.push_back(m_wen);
                m_owner = m_sel;
                m_cnt++;
                if (req_last[m_sel] || m_cnt == MAX_BURST) begin
                    m_busy = 1'b0;
                    m_cnt  = 0;
                    m_ptr  = (m_sel + 1) % NUM_REQ;
                end else begin
                    m_busy = 1'b1;
                end
            end
        end
    end

    task automatic drive(int i, bit v, int a, bit l);
        logic [31:0] av;
        av = 32'(a);
        req_valid[i] = v;
        req_last[i]  = l;
        req_addr[i*ADDR_W +: ADDR_W] = av[ADDR_W-1:0];
        req_data[i*DATA_W +: DATA_W] = DATA_W'($urandom);
    endtask

    task automatic step(int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drop_all();
        req_valid = '0;
        req_last  = '0;
    endtask

    initial begin
        #100000;
        n_fail++;
        $display("FAIL watchdog: got timeout expected finish");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        req_valid = '0;
        req_last  = '0;
        req_addr  = '0;
        req_data  = '0;
        @(posedge clk);
        #1;
        checking = 1'b1;
        step(2);
        rst = 1'b0;
        step(2);
        gnt_log.delete();

        // All four valid, single transfers: plain rotation.
        for (int i = 0; i < NUM_REQ; i++) drive(i, 1'b1, i + 1, 1'b1);
        step(5);
        drop_all();
        step(2);
        exp_log = '{0, 1, 2, 3, 0};
        check_log("rr_order");

        // Single grant to 1 moves rr_ptr to 2, then 2 bursts over valid 0 and 1.
        drive(1, 1'b1, 0, 1'b1);
        step(1);
        drop_all();
        step(1);
        drive(0, 1'b1, 0, 1'b1);
        drive(1, 1'b1, 1, 1'b1);
        drive(2, 1'b1, 5, 1'b0);
        step(1);
        drive(2, 1'b1, 6, 1'b0);
        step(1);
        drive(2, 1'b1, 7 - NUM_REGS + 4, 1'b1);
        step(1);
        drive(2, 1'b0, 0, 1'b0);
        step(2);
        drop_all();
        step(2);
        exp_log = '{1, 2, 2, 2, 0, 1};
        check_log("burst_last");

        // Owner never asserts last: forced release after MAX_BURST, then 3 wins.
        drive(2, 1'b1, 4, 1'b0);
        drive(3, 1'b1, 3, 1'b1);
        step(5);
        drop_all();
        step(2);
        exp_log = '{2, 2, 2, 2, 3};
        check_log("forced_release");

        // Owner stalls mid-burst; requester 1 must not sneak in.
        drive(0, 1'b1, 1, 1'b0);
        drive(1, 1'b1, 2, 1'b1);
        step(1);
        drive(0, 1'b0, 1, 1'b0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check_val("stall_rdy1", 64'(req_ready[1]), 64'd0);
            if (k > 0) check_val("stall_wen", 64'(reg_w_en), 64'd0);
            check_val("stall_busy", 64'(busy), 64'd1);
            @(posedge clk);
            #1;
        end
        drive(0, 1'b1, 3, 1'b1);
        step(1);
        drive(0, 1'b0, 0, 1'b0);
        step(1);
        drop_all();
        step(2);
        exp_log = '{0, 0, 1};
        check_log("stall_resume");

        // Out-of-range address 7 with 6 registers.
        drive(3, 1'b1, 7, 1'b1);
        step(1);
        drop_all();
        @(negedge clk);
        check_val("oor_wen", 64'(reg_w_en), 64'd0);
        step(2);
        check_val("oor_err", 64'(err), 64'(ERR_EN));
        exp_log = '{3};
        check_log("oor_grant");

        // Reset the cycle after a burst-opening transfer.
        drive(2, 1'b1, 4, 1'b0);
        step(1);
        rst = 1'b1;
        @(negedge clk);
        check_val("rst_rdy", 64'(req_ready), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        drop_all();
        @(negedge clk);
        check_val("rst_wen", 64'(reg_w_en), 64'd0);
        check_val("rst_wdata", 64'(reg_wdata), 64'd0);
        check_val("rst_busy", 64'(busy), 64'd0);
        check_val("rst_grant", 64'(grant_id), 64'd0);
        check_val("rst_err", 64'(err), 64'd0);
        step(3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
